rgb_frame_reader: RTL

Downstream neighbour of the YUV-to-RGB colourspace converter. Reads the interleaved RGB frame from the SRAM RGB segment: 3 words per pixel pair, {R0,G0},{B0,R1},{G1,B1}. The frame is 320x240 at word base 146944. Delivers one pixel per accepted request to the display/VGA side through a small pair FIFO. The block only reads SRAM; it never writes it.

---
 rtl/rgb_reader_pkg.sv | 29 ++
 rtl/rgb_pair_fifo.sv | 61 ++++++
 rtl/rgb_frame_reader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_reader_pkg.sv
// Shared types and frame defaults for the RGB frame reader.
// Imported by the pair FIFO and the top-level reader.
package rgb_reader_pkg;

  localparam logic [17:0] DEF_RGB_BASE = 18'd146944;
  localparam int DEF_IMG_WIDTH = 320;
  localparam int DEF_IMG_HEIGHT = 240;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pixel_t;

  typedef struct packed {
    rgb_pixel_t even;
    rgb_pixel_t odd;
  } rgb_pair_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_WAIT,
    S_DRAIN
  } rgb_reader_state_t;

endpackage

// File: rtl/rgb_pair_fifo.sv
// Synchronous FIFO of RGB pixel pairs with a registered count.
// Push when full and pop when empty are ignored.
module rgb_pair_fifo
  import rgb_reader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  rgb_pair_t                din,
  output rgb_pair_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  rgb_pair_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array: written on push, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rgb_frame_reader.sv
// Reads the interleaved RGB frame from SRAM, one pixel per request.
// Optional underrun_count output when RGB_UNDERRUN_CNT_EN is defined.
module rgb_frame_reader
  import rgb_reader_pkg::*;
#(
  parameter logic [17:0] RGB_BASE   = DEF_RGB_BASE,
  parameter int          IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int          IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  output logic        Busy,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  input  logic        pixel_req,
  output logic        pixel_valid,
  output logic [7:0]  pixel_R,
  output logic [7:0]  pixel_G,
  output logic [7:0]  pixel_B,
  output logic [8:0]  pixel_X,
  output logic [7:0]  pixel_Y,
  output logic        frame_done,
  output logic        underrun
`ifdef RGB_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  localparam int NPAIRS = IMG_WIDTH * IMG_HEIGHT / 2;
  localparam int PCW    = $clog2(NPAIRS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  rgb_reader_state_t state, nstate;

  logic [17:0]  word_ptr;
  logic [17:0]  addr_q;
  logic [PCW-1:0] pair_cnt;
  logic [CW-1:0]  inflight;
  logic [CW:0]    credit;
  logic         credit_ok;
  logic         last_pair;
  logic         reserve;
  logic         fetching;
  logic [1:0]   phase;
  logic         v1, v2;
  logic [1:0]   ph1, ph2;
  logic [15:0]  w0, w1;
  logic         push;
  logic         pop;
  logic         accept;
  logic         last_acc;
  logic         start_ok;
  logic         starve;
  logic         sel;
  rgb_pair_t    din;
  rgb_pair_t    head;
  rgb_pixel_t   hpx;
  logic         full;
  logic         empty;
  logic [CW-1:0]  fcount;

  rgb_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fcount)
  );

  assign SRAM_we_n   = 1'b1;
  assign pixel_valid = ~empty;
  assign credit      = {1'b0, fcount} + {1'b0, inflight};
  assign credit_ok   = credit < (CW+1)'(FIFO_DEPTH);
  assign last_pair   = pair_cnt == PCW'(NPAIRS - 1);
  assign fetching    = (state == S_FETCH0) ||
                       (state == S_FETCH1) ||
                       (state == S_FETCH2);
  assign SRAM_address = fetching ? word_ptr : addr_q;
  assign start_ok    = (state == S_IDLE) && Start;
  assign accept      = pixel_req & pixel_valid & Busy;
  assign pop         = accept & sel;
  assign starve      = pixel_req & Busy & ~pixel_valid;
  assign last_acc    = accept && (state == S_DRAIN) &&
                       (pixel_X == 9'(IMG_WIDTH - 1)) &&
                       (pixel_Y == 8'(IMG_HEIGHT - 1));
  assign push        = v2 && (ph2 == 2'd2);
  assign din.even    = '{r: w0[15:8], g: w0[7:0], b: w1[15:8]};
  assign din.odd     = '{r: w1[7:0],
                         g: SRAM_read_data[15:8],
                         b: SRAM_read_data[7:0]};

  // Word index within the triple being issued
  always_comb begin
    phase = 2'd0;
    unique case (state)
      S_FETCH1: phase = 2'd1;
      S_FETCH2: phase = 2'd2;
      default:  phase = 2'd0;
    endcase
  end

  // Fetch FSM: next state and credit reservation
  always_comb begin
    nstate  = state;
    reserve = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Start) nstate = S_WAIT;
      end
      S_WAIT: begin
        if (credit_ok) begin
          nstate  = S_FETCH0;
          reserve = 1'b1;
        end
      end
      S_FETCH0: nstate = S_FETCH1;
      S_FETCH1: nstate = S_FETCH2;
      S_FETCH2: begin
        if (last_pair) begin
          nstate = S_DRAIN;
        end else if (credit_ok) begin
          nstate  = S_FETCH0;
          reserve = 1'b1;
        end else begin
          nstate = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (last_acc) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // State register, issue pointer and credit bookkeeping
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      word_ptr <= RGB_BASE;
      addr_q   <= RGB_BASE;
      pair_cnt <= '0;
      inflight <= '0;
    end else begin
      state <= nstate;
      if (fetching) begin
        word_ptr <= word_ptr + 18'd1;
        addr_q   <= word_ptr;
      end
      if (state == S_FETCH2) begin
        pair_cnt <= pair_cnt + 1'b1;
      end
      unique case ({reserve, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (last_acc) begin
        word_ptr <= RGB_BASE;
        addr_q   <= RGB_BASE;
        pair_cnt <= '0;
      end
    end
  end

  // Capture pipeline: track issued words, latch them on arrival
  always_ff @(posedge Clock) begin
    if (Reset) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      ph1 <= 2'd0;
      ph2 <= 2'd0;
      w0  <= '0;
      w1  <= '0;
    end else begin
      v1  <= fetching;
      ph1 <= phase;
      v2  <= v1;
      ph2 <= ph1;
      if (v2 && ph2 == 2'd0) w0 <= SRAM_read_data;
      if (v2 && ph2 == 2'd1) w1 <= SRAM_read_data;
    end
  end

  // Consumer side: half select, pixel position, status flags
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel        <= 1'b0;
      pixel_X    <= '0;
      pixel_Y    <= '0;
      Busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= last_acc;
      if (start_ok) begin
        Busy     <= 1'b1;
        underrun <= 1'b0;
      end
      if (starve) underrun <= 1'b1;
      if (accept) begin
        sel <= ~sel;
        if (pixel_X == 9'(IMG_WIDTH - 1)) begin
          pixel_X <= '0;
          pixel_Y <= pixel_Y + 8'd1;
        end else begin
          pixel_X <= pixel_X + 9'd1;
        end
      end
      if (last_acc) begin
        Busy    <= 1'b0;
        sel     <= 1'b0;
        pixel_X <= '0;
        pixel_Y <= '0;
      end
    end
  end

  // Head pixel colour, forced to zero while the FIFO is empty
  always_comb begin
    hpx     = sel ? head.odd : head.even;
    pixel_R = 8'd0;
    pixel_G = 8'd0;
    pixel_B = 8'd0;
    if (pixel_valid) begin
      pixel_R = hpx.r;
      pixel_G = hpx.g;
      pixel_B = hpx.b;
    end
  end

`ifdef RGB_UNDERRUN_CNT_EN
  // Saturating count of starved request cycles
  always_ff @(posedge Clock) begin
    if (Reset) begin
      underrun_count <= '0;
    end else if (start_ok) begin
      underrun_count <= '0;
    end else if (starve && underrun_count != 16'hFFFF) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule
